demux_stream_router: RTL and testbench

Parametrised, registered 1-to-N stream demultiplexer with a valid/ready handshake on the input and on every output channel. Each accepted input word goes either to the single channel addressed by `sel` (unicast) or to all channels at once (broadcast). Every channel has its own one-entry output register, so a stalled consumer blocks only its own channel. The block replaces the combinational 1-to-8 bit demux wherever multi-bit data must be steered to several back-pressured consumers.

---
 rtl/demux_stream_router.sv | 88 ++++++++
 tb/tb_demux_stream_router.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_router.sv
// Purpose: registered 1-to-N valid/ready stream demux; unicast to channel sel or broadcast to all.
// Latency: 1 cycle from accept to out_valid/out_data; acc_count updates on the same edge.
// Backpressure: in_ready combinational from per-channel free state; a stalled channel blocks only
//               unicasts to itself and all broadcasts.
// Ports:
//   clk, rst (sync active-high), en          - clock, reset, accept enable
//   in_valid/in_ready/in_data, sel, mode     - input stream; mode 0 = unicast to sel, 1 = broadcast
//   out_valid[N], out_ready[N], out_data     - per-channel output; channel k at out_data[k*WIDTH +: WIDTH]
//   acc_count                                - accepted input words, wraps modulo 2**CNT_W
module demux_stream_router #(
  parameter int WIDTH    = 8,
  parameter int SEL_BITS = 3,
  parameter int CNT_W    = 16,
  localparam int N       = 2**SEL_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_BITS-1:0]  sel,
  input  logic                 mode,
  output logic                 in_ready,
  output logic [N-1:0]         out_valid,
  output logic [N*WIDTH-1:0]   out_data,
  input  logic [N-1:0]         out_ready,
  output logic [CNT_W-1:0]     acc_count
);

  logic [N-1:0]     valid_q;
  logic [WIDTH-1:0] data_q [N];
  logic [CNT_W-1:0] cnt_q;

  logic [N-1:0] free;
  logic [N-1:0] tgt;
  logic         accept;

  // A channel can take a word if it is empty or its current word leaves this cycle.
  assign free = ~valid_q | out_ready;

  always_comb begin
    in_ready = 1'b0;
    if (!rst && en) begin
      in_ready = mode ? (&free) : free[sel];
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    tgt = '0;
    for (int k = 0; k < N; k++) begin
      tgt[k] = accept && (mode || (sel == SEL_BITS'(k)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < N; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        // Load takes priority over drain so back-to-back words are never dropped.
        if (tgt[k]) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= in_data;
        end else if (valid_q[k] && out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      // A broadcast is one accepted word, so it counts once.
      if (accept) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = valid_q;
  assign acc_count = cnt_q;

  for (genvar k = 0; k < N; k++) begin : g_out
    assign out_data[k*WIDTH +: WIDTH] = data_q[k];
  end

endmodule

// File: tb/tb_demux_stream_router.sv
module tb_demux_stream_router;

  localparam int W  = 8;
  localparam int SB = 3;
  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic [SB-1:0] sel;
  logic          mode;
  logic          in_ready;
  logic [N-1:0]  out_valid;
  logic [N*W-1:0] out_data;
  logic [N-1:0]  out_ready;
  logic [CW-1:0] acc_count;

  int n_chk = 0;
  int n_err = 0;
  bit mon_on = 0;

  // Reference model: per-channel queue of words delivered but not yet consumed,
  // last word ever delivered per channel, and accepted-word count.
  logic [W-1:0] sbq [N][$];
  logic [W-1:0] last_dat [N];
  int           model_cnt = 0;
  bit           exp_rdy = 0;

  demux_stream_router #(.WIDTH(W), .SEL_BITS(SB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .sel(sel), .mode(mode), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .acc_count(acc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares all outputs against the model away from the active edge and
  // pops words that the consumer takes at the coming edge.
  always @(negedge clk) begin
    if (mon_on) begin
      bit all_free;
      bit fr [N];
      all_free = 1;
      for (int k = 0; k < N; k++) begin
        fr[k] = (sbq[k].size() == 0) || out_ready[k];
        all_free &= fr[k];
      end
      exp_rdy = !rst && en && (mode ? all_free : fr[sel]);
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("acc_count", 64'(acc_count), 64'(model_cnt));
      for (int k = 0; k < N; k++) begin
        chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(sbq[k].size() != 0));
        chk($sformatf("out_data[%0d]", k), 64'(out_data[k*W +: W]), 64'(last_dat[k]));
        if (out_valid[k] && out_ready[k] && sbq[k].size() != 0) begin
          logic [W-1:0] e;
          e = sbq[k].pop_front();
          chk($sformatf("drain[%0d]", k), 64'(out_data[k*W +: W]), 64'(e));
        end
      end
    end
  end

  // Stimulus-side observer: pushes the expected delivery of each accepted word.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        sbq[k].delete();
        last_dat[k] = '0;
      end
      model_cnt = 0;
    end else if (mon_on && in_valid && exp_rdy) begin
      for (int k = 0; k < N; k++) begin
        if (mode || sel == SB'(k)) begin
          sbq[k].push_back(in_data);
          last_dat[k] = in_data;
        end
      end
      model_cnt = (model_cnt + 1) % (1 << CW);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic uni(input int s, input int d);
    mode = 0; sel = SB'(s); in_data = W'(d); in_valid = 1;
    step();
    in_valid = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    rst = 1; en = 0; in_valid = 0; in_data = '0; sel = '0; mode = 0; out_ready = '1;
    step();
    mon_on = 1;
    step();
    chk("in_ready during reset", 64'(in_ready), 64'(0));
    rst = 0;
    step();
    chk("reset out_valid", 64'(out_valid), 64'(0));
    chk("reset out_data", out_data, 64'(0));
    chk("reset acc_count", 64'(acc_count), 64'(0));

    // Reset then unicast
    en = 1;
    uni(5, 8'hA5);
    chk("uni out_valid", 64'(out_valid), 64'h20);
    chk("uni slice5", 64'(out_data[5*W +: W]), 64'hA5);
    chk("uni acc", 64'(acc_count), 64'd1);
    step();
    chk("uni one cycle", 64'(out_valid), 64'h0);

    // Back-pressure on channel 2
    out_ready[2] = 0;
    uni(2, 8'h11);
    chk("bp hold valid", 64'(out_valid[2]), 64'd1);
    mode = 0; sel = 2; in_data = 8'h22; in_valid = 1;
    #1;
    chk("bp blocked in_ready", 64'(in_ready), 64'd0);
    step();
    chk("bp hold data", 64'(out_data[2*W +: W]), 64'h11);
    sel = 3; in_data = 8'h33;
    #1;
    chk("bp other chan ready", 64'(in_ready), 64'd1);
    step();
    chk("bp chan3", 64'(out_data[3*W +: W]), 64'h33);
    sel = 2; in_data = 8'h22; out_ready[2] = 1;
    #1;
    chk("bp drain ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 0;
    chk("bp second word", 64'(out_data[2*W +: W]), 64'h22);
    step();

    // Streaming into channel 7
    for (int i = 1; i <= 8; i++) begin
      mode = 0; sel = 7; in_data = W'(i); in_valid = 1;
      #1;
      chk("stream in_ready", 64'(in_ready), 64'd1);
      step();
      chk("stream data", 64'(out_data[7*W +: W]), 64'(i));
      chk("stream valid", 64'(out_valid[7]), 64'd1);
    end
    in_valid = 0;
    step();

    // Broadcast, then broadcast blocked by a full channel 4
    mode = 1; in_data = 8'h3C; in_valid = 1;
    step();
    in_valid = 0;
    chk("bcast valid", 64'(out_valid), 64'hFF);
    chk("bcast data", out_data, 64'h3C3C3C3C3C3C3C3C);
    step();
    out_ready[4] = 0;
    uni(4, 8'h44);
    mode = 1; in_data = 8'h3C; in_valid = 1;
    #1;
    chk("bcast stalled", 64'(in_ready), 64'd0);
    step();
    step();
    out_ready[4] = 1;
    #1;
    chk("bcast released", 64'(in_ready), 64'd1);
    step();
    in_valid = 0;
    chk("bcast2 valid", 64'(out_valid), 64'hFF);
    step();

    // Enable low: no acceptance, buffered word still drains
    out_ready[1] = 0;
    uni(1, 8'h5A);
    en = 0; mode = 0; sel = 6; in_valid = 1;
    #1;
    chk("en low in_ready", 64'(in_ready), 64'd0);
    step();
    out_ready[1] = 1;
    step();
    chk("en low drained", 64'(out_valid), 64'h0);
    in_valid = 0; en = 1;

    // Reset mid-operation with three full channels
    out_ready = '0;
    uni(0, 8'h01);
    uni(3, 8'h03);
    uni(6, 8'h06);
    chk("pre-reset full", 64'(out_valid), 64'h49);
    rst = 1;
    step();
    rst = 0;
    chk("mid reset valid", 64'(out_valid), 64'h0);
    chk("mid reset data", out_data, 64'h0);
    chk("mid reset acc", 64'(acc_count), 64'h0);
    out_ready = '1;

    // Counter wrap with a 4-bit counter
    for (int i = 1; i <= 17; i++) begin
      uni(int'($urandom_range(0, N-1)), int'($urandom_range(0, 255)));
      if (i == 15) chk("wrap 15", 64'(acc_count), 64'd15);
      if (i == 16) chk("wrap 16", 64'(acc_count), 64'd0);
      if (i == 17) chk("wrap 17", 64'(acc_count), 64'd1);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 149) == 0);
      en        = ($urandom_range(0, 7) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      mode      = ($urandom_range(0, 4) == 0);
      sel       = SB'($urandom_range(0, N-1));
      in_data   = W'($urandom);
      out_ready = N'($urandom) | N'($urandom);
      step();
    end
    rst = 0; in_valid = 0; out_ready = '1;
    step();
    step();
    mon_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
